// File: rtl/pool_win_feeder_pkg.sv
// Shared pooling package: default stream/SRAM geometry, the feeder FSM
// state encoding and a helper that validates map dimensions.
package pool_win_feeder_pkg;

   localparam int DATA_W = 8;    // bits per activation lane
   localparam int LANES  = 16;   // lanes per SRAM word / stream beat
   localparam int ADDR_W = 12;   // SRAM word-address width
   localparam int DIM_W  = 6;    // row/column count width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } pool_state_e;

   // A map is walkable in 2x2 windows only if both dimensions are even and non-zero.
   function automatic logic cfg_dims_legal(input logic [DIM_W-1:0] w,
                                           input logic [DIM_W-1:0] h);
      return (w != '0) && (h != '0) && !w[0] && !h[0];
   endfunction

endpackage

// File: rtl/pool_win_feeder_if.sv
// Configuration, SRAM read port and POOL stream bundle of the window feeder.
// The feeder uses the master view; the surrounding fabric uses the slave view.
interface pool_win_feeder_if #(
   parameter int DATA_W = pool_win_feeder_pkg::DATA_W,
   parameter int LANES  = pool_win_feeder_pkg::LANES,
   parameter int ADDR_W = pool_win_feeder_pkg::ADDR_W,
   parameter int DIM_W  = pool_win_feeder_pkg::DIM_W
);

   // configuration / status
   logic                    cfg_start;
   logic [ADDR_W-1:0]       cfg_base;
   logic [DIM_W-1:0]        cfg_width;
   logic [DIM_W-1:0]        cfg_height;
   logic                    busy;
   logic                    done;

   // activation SRAM read port
   logic                    sram_rd_en;
   logic [ADDR_W-1:0]       sram_rd_addr;
   logic [LANES*DATA_W-1:0] sram_rd_data;

   // beat stream toward POOL
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*DATA_W-1:0] out_data;
   logic                    out_win_last;
   logic                    out_map_last;

   modport master (
      input  cfg_start, cfg_base, cfg_width, cfg_height, sram_rd_data, out_ready,
      output busy, done, sram_rd_en, sram_rd_addr,
             out_valid, out_data, out_win_last, out_map_last
   );

   modport slave (
      output cfg_start, cfg_base, cfg_width, cfg_height, sram_rd_data, out_ready,
      input  busy, done, sram_rd_en, sram_rd_addr,
             out_valid, out_data, out_win_last, out_map_last
   );

endinterface

// File: rtl/pool_win_feeder_skid_fifo.sv
// Two-entry skid FIFO holding SRAM read data plus its window/map flags.
// The head entry is a register, so the output is stable while stalled.
module pool_skid_fifo #(
   parameter int W = 130
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic [W-1:0] entries [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [W-1:0] entry_q, entry_d;

         // Capture incoming data when the write pointer selects this slot.
         always_comb begin
            entry_d = entry_q;
            if (push && (wr_ptr_q == 1'(gi)))
               entry_d = push_data;
         end

         // Slot storage register.
         always_ff @(posedge clk) begin
            if (rst) entry_q <= '0;
            else     entry_q <= entry_d;
         end

         assign entries[gi] = entry_q;
      end
   endgenerate

   // Pointer and occupancy update; push and pop together leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Debug-only guards: the issuing logic must never overflow or underflow us.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (count_q == 2'd2)));
         assert (!(pop && (count_q == 2'd0)));
      end
   end

   assign head_data = entries[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/pool_win_feeder.sv
// Pool window feeder: walks one activation map in 2x2 window order, reading
// the SRAM and streaming beats to POOL through a 2-entry skid FIFO.
module pool_win_feeder #(
   parameter int DATA_W = pool_win_feeder_pkg::DATA_W,
   parameter int LANES  = pool_win_feeder_pkg::LANES,
   parameter int ADDR_W = pool_win_feeder_pkg::ADDR_W,
   parameter int DIM_W  = pool_win_feeder_pkg::DIM_W
) (
   input  logic               clk,
   input  logic               rst,
   pool_win_feeder_if.master  bus
);

   import pool_win_feeder_pkg::*;

   localparam int BEAT_W = LANES * DATA_W;

   pool_state_e       state_q, state_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [1:0]        sub_q, sub_d;          // position inside the 2x2 window
   logic [DIM_W-1:0]  col_q, col_d;          // left column of current window
   logic [DIM_W-1:0]  row_q, row_d;          // top row of current window
   logic [ADDR_W-1:0] row_base_q, row_base_d; // address of (row_q, 0)
   logic              rd_pend_q, rd_pend_d;  // read issued last cycle, data arriving now
   logic              pend_win_q, pend_win_d;
   logic              pend_map_q, pend_map_d;

   logic              col_last, row_last, last_read;
   logic              rd_issue;
   logic [2:0]        occupancy;
   logic [ADDR_W-1:0] row_offset, rd_addr_calc;

   logic              fifo_pop;
   logic              fifo_valid;
   logic [1:0]        fifo_count;
   logic [BEAT_W+1:0] fifo_push_data, fifo_head;

   assign col_last  = (col_q == (width_q - DIM_W'(2)));
   assign row_last  = (row_q == (height_q - DIM_W'(2)));
   assign last_read = (sub_q == 2'd3) && col_last && row_last;

   // Space left after this cycle counts buffered beats, reads in flight and the
   // beat leaving now; crediting the pop keeps a full-rate stream with ready high.
   assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};
   assign rd_issue  = (state_q == ST_RUN) && (occupancy < 3'd2);

   // Second row of the window sits one map width further on; wraps modulo 2^ADDR_W.
   assign row_offset   = sub_q[1] ? ADDR_W'(width_q) : '0;
   assign rd_addr_calc = row_base_q + row_offset + ADDR_W'(col_q) + ADDR_W'(sub_q[0]);

   assign bus.sram_rd_en   = rd_issue;
   assign bus.sram_rd_addr = rd_issue ? rd_addr_calc : '0;

   // Next-state, address walk and in-flight flag tracking.
   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      height_d   = height_q;
      sub_d      = sub_q;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      rd_pend_d  = rd_issue;
      pend_win_d = rd_issue && (sub_q == 2'd3);
      pend_map_d = rd_issue && last_read;

      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_start) begin
               width_d    = bus.cfg_width;
               height_d   = bus.cfg_height;
               row_base_d = bus.cfg_base;
               sub_d      = 2'd0;
               col_d      = '0;
               row_d      = '0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_issue) begin
               sub_d = sub_q + 2'd1;
               if (sub_q == 2'd3) begin
                  if (col_last) begin
                     col_d      = '0;
                     row_d      = row_q + DIM_W'(2);
                     row_base_d = row_base_q + (ADDR_W'(width_q) << 1);
                  end else begin
                     col_d = col_q + DIM_W'(2);
                  end
               end
               if (last_read)
                  state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The map-last beat is the final entry, so its acceptance empties the FIFO.
            if (fifo_pop && fifo_head[BEAT_W+1])
               state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and address-generator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         width_q    <= '0;
         height_q   <= '0;
         sub_q      <= 2'd0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         rd_pend_q  <= 1'b0;
         pend_win_q <= 1'b0;
         pend_map_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         width_q    <= width_d;
         height_q   <= height_d;
         sub_q      <= sub_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         rd_pend_q  <= rd_pend_d;
         pend_win_q <= pend_win_d;
         pend_map_q <= pend_map_d;
      end
   end

   // Debug-only: flag an illegal map shape at the moment it is accepted.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == ST_IDLE) && bus.cfg_start)
         assert (cfg_dims_legal(bus.cfg_width, bus.cfg_height));
   end

   assign fifo_push_data = {pend_map_q, pend_win_q, bus.sram_rd_data};
   assign fifo_valid     = (fifo_count != 2'd0);
   assign fifo_pop       = fifo_valid && bus.out_ready;

   pool_skid_fifo #(
      .W (BEAT_W + 2)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend_q),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign bus.out_valid    = fifo_valid;
   assign bus.out_data     = fifo_head[BEAT_W-1:0];
   assign bus.out_win_last = fifo_head[BEAT_W];
   assign bus.out_map_last = fifo_head[BEAT_W+1];

   assign bus.busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pool_win_feeder.sv
// Bench for pool_win_feeder: random SRAM contents, a queue-based model of the
// expected window-order address/beat sequence, and directed map scenarios.
module tb_pool_win_feeder;
   import pool_win_feeder_pkg::*;

   localparam int BW = LANES * DATA_W;

   typedef struct packed {
      logic [BW-1:0] data;
      logic          win;
      logic          map;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pool_win_feeder_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus();

   pool_win_feeder #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // SRAM model with one cycle read latency
   logic [BW-1:0] sram [1 << ADDR_W];
   always @(posedge clk) begin
      if (bus.sram_rd_en) bus.sram_rd_data <= sram[bus.sram_rd_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   beat_t             exp_beats[$];
   logic [ADDR_W-1:0] exp_addr[$];

   int ready_mode = 0;
   int outstanding = 0;
   int beats_acc = 0;
   int done_cnt = 0;
   int cyc = 0;
   int first_rd_cyc = -1;
   int first_beat_cyc = -1;
   int last_beat_cyc = -1;
   int done_cyc = -1;
   logic prev_stall = 1'b0;
   beat_t prev_beat;
   beat_t cur_beat;
   beat_t exp_b;
   logic [ADDR_W-1:0] exp_a;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic check_data(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // out_ready driver: always high, or a fair coin each cycle
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Monitor: reads against expected addresses, beats against expected payload/flags
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_beats.delete();
         exp_addr.delete();
         outstanding = 0;
         prev_stall  = 1'b0;
      end else begin
         cur_beat = beat_t'{data: bus.out_data, win: bus.out_win_last, map: bus.out_map_last};
         if (bus.sram_rd_en) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            check_bit("read_expected", exp_addr.size() > 0, 1'b1);
            if (exp_addr.size() > 0) begin
               exp_a = exp_addr.pop_front();
               check_int("rd_addr", int'(bus.sram_rd_addr), int'(exp_a));
            end
            outstanding++;
         end
         if (prev_stall) begin
            check_bit("stall_valid_held", bus.out_valid, 1'b1);
            check_data("stall_data_held", cur_beat.data, prev_beat.data);
            check_bit("stall_win_held", cur_beat.win, prev_beat.win);
            check_bit("stall_map_held", cur_beat.map, prev_beat.map);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats_acc++;
            outstanding--;
            check_bit("beat_expected", exp_beats.size() > 0, 1'b1);
            if (exp_beats.size() > 0) begin
               exp_b = exp_beats.pop_front();
               check_data("beat_data", bus.out_data, exp_b.data);
               check_bit("win_last", bus.out_win_last, exp_b.win);
               check_bit("map_last", bus.out_map_last, exp_b.map);
            end
         end
         check_bit("buffered_le_2", (outstanding <= 2) && (outstanding >= 0), 1'b1);
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_beat  = cur_beat;
      end
   end

   // Reference: window order, address wraps modulo 2^ADDR_W, flags from the beat index
   task automatic load_map(input logic [ADDR_W-1:0] base, input int w, input int h);
      int n;
      int row;
      int col;
      logic [ADDR_W-1:0] a;
      n = 0;
      for (int r = 0; r < h; r += 2) begin
         for (int c = 0; c < w; c += 2) begin
            for (int k = 0; k < 4; k++) begin
               row = r + k / 2;
               col = c + k % 2;
               a = ADDR_W'(int'(base) + row * w + col);
               exp_addr.push_back(a);
               exp_beats.push_back(beat_t'{data: sram[a], win: (n % 4 == 3), map: (n == w * h - 1)});
               n++;
            end
         end
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] base, input int w, input int h);
      @(posedge clk);
      #1;
      bus.cfg_start  = 1'b1;
      bus.cfg_base   = base;
      bus.cfg_width  = DIM_W'(w);
      bus.cfg_height = DIM_W'(h);
      @(posedge clk);
      #1;
      bus.cfg_start  = 1'b0;
   endtask

   int done_base;

   task automatic begin_map(input logic [ADDR_W-1:0] base, input int w, input int h, input int mode);
      ready_mode     = mode;
      done_base      = done_cnt;
      beats_acc      = 0;
      first_rd_cyc   = -1;
      first_beat_cyc = -1;
      last_beat_cyc  = -1;
      load_map(base, w, h);
      pulse_start(base, w, h);
   endtask

   // Waits for done (bounded); optionally pulses cfg_start during the done cycle
   task automatic finish_map(input string tag, input logic [ADDR_W-1:0] base, input int w, input int h,
                             input bit start_in_done);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      check_bit({tag, "_done_seen"}, seen, 1'b1);
      if (seen && start_in_done) begin
         bus.cfg_start  = 1'b1;
         bus.cfg_base   = 12'h300;
         bus.cfg_width  = DIM_W'(2);
         bus.cfg_height = DIM_W'(2);
         @(posedge clk);
         #1;
         bus.cfg_start  = 1'b0;
      end
      repeat (2) @(negedge clk);
      check_int({tag, "_beats"}, beats_acc, w * h);
      check_int({tag, "_done_pulses"}, done_cnt - done_base, 1);
      check_int({tag, "_addr_left"}, exp_addr.size(), 0);
      check_int({tag, "_beats_left"}, exp_beats.size(), 0);
      $display("map %s base=0x%03h W=%0d H=%0d beats=%0d done_pulses=%0d",
               tag, base, w, h, beats_acc, done_cnt - done_base);
   endtask

   initial begin
      bus.cfg_start  = 1'b0;
      bus.cfg_base   = '0;
      bus.cfg_width  = '0;
      bus.cfg_height = '0;
      for (int i = 0; i < (1 << ADDR_W); i++)
         sram[i] = {$urandom, $urandom, $urandom, $urandom};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_bit("rst_busy", bus.busy, 1'b0);
      check_bit("rst_done", bus.done, 1'b0);
      check_bit("rst_rd_en", bus.sram_rd_en, 1'b0);
      check_int("rst_rd_addr", int'(bus.sram_rd_addr), 0);
      check_bit("rst_out_valid", bus.out_valid, 1'b0);
      check_bit("rst_win_last", bus.out_win_last, 1'b0);
      check_bit("rst_map_last", bus.out_map_last, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 2x2 at 0x010, ready high: latency and back-to-back timing
      begin_map(12'h010, 2, 2, 0);
      finish_map("w2h2", 12'h010, 2, 2, 1'b0);
      check_int("w2h2_read_to_beat", first_beat_cyc - first_rd_cyc, 2);
      check_int("w2h2_beat_span", last_beat_cyc - first_beat_cyc, 3);
      check_int("w2h2_done_after_last", done_cyc - last_beat_cyc, 1);

      // 4x2 at 0: window ordering across columns
      begin_map(12'h000, 4, 2, 0);
      finish_map("w4h2", 12'h000, 4, 2, 1'b0);

      // 4x4 with random backpressure
      begin_map(12'h123, 4, 4, 1);
      finish_map("w4h4_rand", 12'h123, 4, 4, 1'b0);

      // address wrap at the top of the SRAM
      begin_map(12'hFFE, 2, 2, 0);
      finish_map("wrap", 12'hFFE, 2, 2, 1'b0);

      // reset in the middle of a 4x4 map
      begin_map(12'h020, 4, 4, 0);
      for (int i = 0; i < 100 && beats_acc < 5; i++) @(negedge clk);
      check_bit("abort_reached_beat5", beats_acc >= 5, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_bit("abort_out_valid", bus.out_valid, 1'b0);
      check_bit("abort_busy", bus.busy, 1'b0);
      check_bit("abort_done", bus.done, 1'b0);
      repeat (10) @(negedge clk);
      check_int("abort_no_done", done_cnt - done_base, 0);
      $display("map abort base=0x020 W=4 H=4 beats_before_reset=%0d", beats_acc);

      // clean map after the abort, random backpressure
      begin_map(12'h7C0, 4, 4, 1);
      finish_map("after_abort", 12'h7C0, 4, 4, 1'b0);

      // cfg_start while busy and in the done cycle are both ignored
      begin_map(12'h200, 4, 2, 1);
      repeat (3) @(posedge clk);
      #1;
      check_bit("busy_while_running", bus.busy, 1'b1);
      bus.cfg_start  = 1'b1;
      bus.cfg_base   = 12'h100;
      bus.cfg_width  = DIM_W'(2);
      bus.cfg_height = DIM_W'(2);
      @(posedge clk);
      #1;
      bus.cfg_start  = 1'b0;
      finish_map("restart_ignored", 12'h200, 4, 2, 1'b1);
      repeat (8) @(negedge clk);
      check_bit("idle_after_ignored_start", bus.busy, 1'b0);
      check_int("no_extra_done", done_cnt - done_base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
